// File: rtl/operand_fifo_if.sv
// Handshake bundle between the operand source (master) and operand_fifo (slave).
// Carries push/pop requests, the head operand pair and the occupancy/status flags.
interface operand_fifo_if #(
    parameter int N     = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          write_en;
    logic [N-1:0]  write_data;
    logic [N-1:0]  write_data2;
    logic          read_en;
    logic [N-1:0]  read_data;
    logic [N-1:0]  read_data2;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    modport master (
        output write_en, write_data, write_data2, read_en,
        input  read_data, read_data2, full, empty, count, overflow, underflow
    );

    modport slave (
        input  write_en, write_data, write_data2, read_en,
        output read_data, read_data2, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/operand_fifo.sv
// First-word-fall-through FIFO of operand pairs for the adder datapath,
// with sticky overflow/underflow flags and a separately held occupancy count.
module operand_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    operand_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]  mem_a_q [DEPTH];
    logic [N-1:0]  mem_b_q [DEPTH];

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          full, empty, push, pop;

    always_comb begin
        full        = (count_q == CW'(DEPTH));
        empty       = (count_q == '0);
        // A full FIFO still takes a push when the head leaves in the same cycle.
        push        = bus.write_en && (!full || bus.read_en);
        pop         = bus.read_en && !empty;

        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push) wp_d = wp_q + AW'(1);
        if (pop)  rp_d = rp_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (bus.write_en && !push) overflow_d  = 1'b1;
        if (bus.read_en && !pop)   underflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Operand storage carries no reset; empty gating hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wp_q] <= bus.write_data;
            mem_b_q[wp_q] <= bus.write_data2;
        end
    end

    assign bus.read_data  = empty ? '0 : mem_a_q[rp_q];
    assign bus.read_data2 = empty ? '0 : mem_b_q[rp_q];
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_operand_fifo.sv
// Directed bench for operand_fifo: a driver queues the expected head pair for
// every accepted pop, and a negedge monitor compares whatever the FIFO presents.
module tb_operand_fifo;
    localparam int N     = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    logic [2*N-1:0] exp_q [$];

    operand_fifo_if #(.N(N), .DEPTH(DEPTH)) bus ();

    operand_fifo #(.N(N), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: a pop the DUT will accept this cycle must show the queued head.
    always @(negedge clk) begin
        if (!rst && bus.read_en && !bus.empty) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got %0h_%0h expected none",
                         bus.read_data, bus.read_data2);
            end else begin
                logic [2*N-1:0] e;
                e = exp_q.pop_front();
                chk("head_pair", {bus.read_data, bus.read_data2}, e);
            end
        end
    end

    // One clock edge with the given request; returns at posedge+1 with requests idle.
    task automatic cyc(input logic we, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic re, input logic exp_pop,
                       input logic [N-1:0] ea, input logic [N-1:0] eb);
        bus.write_en    = we;
        bus.write_data  = a;
        bus.write_data2 = b;
        bus.read_en     = re;
        if (exp_pop) exp_q.push_back({ea, eb});
        @(posedge clk);
        #1;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
    endtask

    task automatic push(input logic [N-1:0] a, input logic [N-1:0] b);
        cyc(1'b1, a, b, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic pop(input logic [N-1:0] ea, input logic [N-1:0] eb);
        cyc(1'b0, '0, '0, 1'b1, 1'b1, ea, eb);
    endtask

    task automatic fill_1_to_8();
        push(1, 2); push(3, 4); push(5, 6); push(7, 8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.write_en    = 1'b0;
        bus.write_data  = '0;
        bus.write_data2 = '0;
        bus.read_en     = 1'b0;
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state, then asynchronous reset with two entries held
        chk("idle_empty", bus.empty, 1);
        chk("idle_count", bus.count, 0);
        push(32'h11, 32'h22);
        push(32'h33, 32'h44);
        chk("two_count", bus.count, 2);
        #2 rst = 1'b1;
        #1;
        chk("async_empty", bus.empty, 1);
        chk("async_full", bus.full, 0);
        chk("async_count", bus.count, 0);
        chk("async_rdata", {bus.read_data, bus.read_data2}, 0);
        #2 rst = 1'b0;
        push(32'hA5A5A5A5, 32'h5A5A5A5A);
        chk("post_rst_head", {bus.read_data, bus.read_data2}, 64'hA5A5A5A5_5A5A5A5A);
        chk("post_rst_count", bus.count, 1);
        pop(32'hA5A5A5A5, 32'h5A5A5A5A);
        chk("post_rst_drain", bus.empty, 1);

        // Fill, overflow, ordered drain
        fill_1_to_8();
        chk("fill_full", bus.full, 1);
        chk("fill_count", bus.count, 4);
        push(9, 10);
        chk("ovf_count", bus.count, 4);
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_head", {bus.read_data, bus.read_data2}, {32'd1, 32'd2});
        pop(1, 2); pop(3, 4); pop(5, 6); pop(7, 8);
        chk("drain_empty", bus.empty, 1);
        chk("drain_rdata", {bus.read_data, bus.read_data2}, 0);
        chk("ovf_sticky", bus.overflow, 1);

        // Full with simultaneous push and pop
        fill_1_to_8();
        cyc(1'b1, 9, 10, 1'b1, 1'b1, 1, 2);
        chk("fullrw_count", bus.count, 4);
        chk("fullrw_head", {bus.read_data, bus.read_data2}, {32'd3, 32'd4});
        pop(3, 4); pop(5, 6); pop(7, 8); pop(9, 10);
        chk("fullrw_empty", bus.empty, 1);

        // Empty with simultaneous push and pop
        chk("udf_clear", bus.underflow, 0);
        cyc(1'b1, 11, 12, 1'b1, 1'b0, '0, '0);
        chk("emprw_count", bus.count, 1);
        chk("emprw_udf", bus.underflow, 1);
        chk("emprw_head", {bus.read_data, bus.read_data2}, {32'd11, 32'd12});
        pop(11, 12);

        // Flags clear only on reset
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_udf", bus.underflow, 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Wrap-around with alternating push/pop
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) push(i, i + 16);
            else            pop(i - 1, i + 15);
            chk("wrap_count_le1", bus.count <= 1, 1);
            if (i == 6) chk("wrap_wp", dut.wp_q, 0);
            if (i == 7) chk("wrap_rp", dut.rp_q, 0);
        end
        chk("wrap_empty", bus.empty, 1);

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
